// File: rtl/mmcm_drp_sequencer.sv
// rtl/mmcm_drp_sequencer.sv - DRP read-modify-write sequencer that reprograms the MMCM CLKOUT1 divide
// Optional readback verification of both registers: define MMCM_DRP_VERIFY_EN.
module mmcm_drp_sequencer #(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRP_TIMEOUT  = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    input  logic [7:0]  cfg_div,
    output logic        cfg_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic        drp_drdy
);
    localparam int TMAX = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [6:0] ADDR_REG1 = 7'h0A;
    localparam logic [6:0] ADDR_REG2 = 7'h0B;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_RST_ON, S_RD1, S_WR1, S_RD2, S_WR2,
`ifdef MMCM_DRP_VERIFY_EN
        S_VRF1, S_VRF2,
`endif
        S_RST_OFF, S_WAIT_LOCK, S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [15:0]   rd1_q, rd1_d, rd2_q, rd2_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic          done_q, done_d;
    logic [1:0]    status_q, status_d;
    logic          mmcm_rst_q, mmcm_rst_d;
    logic [6:0]    drp_daddr_q, drp_daddr_d;
    logic [15:0]   drp_di_q, drp_di_d;
    logic          drp_den_q, drp_den_d, drp_dwe_q, drp_dwe_d;
    logic          locked_meta_q, locked_meta_d, locked_sync_q, locked_sync_d;

    logic          acc_en, acc_wr, acc_ok, acc_to;
    logic [6:0]    acc_addr;
    logic [15:0]   acc_data;
    logic [5:0]    high6, low6;
    logic [15:0]   reg1_val, reg2_val;

    // 6-bit fields wrap naturally, so a divide of 128 encodes as 0/0 (the MMCM's 64 count).
    assign high6    = div_q[6:1];
    assign low6     = div_q[5:0] - div_q[6:1];
    assign reg1_val = (rd1_q & 16'hF000) | {4'b0, high6, low6};
    assign reg2_val = (rd2_q & 16'hFF3F) | {8'b0, div_q[0], (div_q == 8'd1), 6'b0};

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        rd1_d         = rd1_q;
        rd2_d         = rd2_q;
        timer_d       = timer_q;
        pending_d     = pending_q;
        done_d        = 1'b0;
        status_d      = status_q;
        mmcm_rst_d    = mmcm_rst_q;
        drp_daddr_d   = drp_daddr_q;
        drp_di_d      = drp_di_q;
        drp_den_d     = 1'b0;
        drp_dwe_d     = 1'b0;
        locked_meta_d = mmcm_locked;
        locked_sync_d = locked_meta_q;
        acc_en        = 1'b0;
        acc_wr        = 1'b0;
        acc_addr      = ADDR_REG1;
        acc_data      = '0;
        acc_ok        = 1'b0;
        acc_to        = 1'b0;

        case (state_q)
            S_RD1: acc_en = 1'b1;
            S_WR1: begin acc_en = 1'b1; acc_wr = 1'b1; acc_data = reg1_val; end
            S_RD2: begin acc_en = 1'b1; acc_addr = ADDR_REG2; end
            S_WR2: begin acc_en = 1'b1; acc_wr = 1'b1; acc_addr = ADDR_REG2; acc_data = reg2_val; end
`ifdef MMCM_DRP_VERIFY_EN
            S_VRF1: acc_en = 1'b1;
            S_VRF2: begin acc_en = 1'b1; acc_addr = ADDR_REG2; end
`endif
            default: acc_en = 1'b0;
        endcase

        // One den per access; a drdy only counts while our own access is outstanding.
        if (acc_en) begin
            if (!pending_q) begin
                drp_den_d   = 1'b1;
                drp_dwe_d   = acc_wr;
                drp_daddr_d = acc_addr;
                drp_di_d    = acc_data;
                pending_d   = 1'b1;
                timer_d     = '0;
            end else if (drp_drdy) begin
                pending_d = 1'b0;
                acc_ok    = 1'b1;
            end else if (timer_q == TW'(DRP_TIMEOUT - 1)) begin
                pending_d = 1'b0;
                acc_to    = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE: if (cfg_valid) begin
                div_d   = cfg_div;
                state_d = S_CHECK;
            end
            S_CHECK: if (div_q == 8'd0 || div_q > 8'd128) begin
                status_d = 2'd1;
                state_d  = S_FIN;
            end else begin
                state_d = S_RST_ON;
            end
            S_RST_ON: begin
                mmcm_rst_d = 1'b1;
                state_d    = S_RD1;
            end
            S_RD1: if (acc_ok) begin rd1_d = drp_do; state_d = S_WR1; end
            S_WR1: if (acc_ok) state_d = S_RD2;
            S_RD2: if (acc_ok) begin rd2_d = drp_do; state_d = S_WR2; end
`ifdef MMCM_DRP_VERIFY_EN
            S_WR2: if (acc_ok) state_d = S_VRF1;
            S_VRF1: if (acc_ok) begin
                if (drp_do != reg1_val) begin
                    status_d = 2'd2; mmcm_rst_d = 1'b0; state_d = S_FIN;
                end else begin
                    state_d = S_VRF2;
                end
            end
            S_VRF2: if (acc_ok) begin
                if (drp_do != reg2_val) begin
                    status_d = 2'd2; mmcm_rst_d = 1'b0; state_d = S_FIN;
                end else begin
                    state_d = S_RST_OFF;
                end
            end
`else
            S_WR2: if (acc_ok) state_d = S_RST_OFF;
`endif
            S_RST_OFF: begin
                mmcm_rst_d = 1'b0;
                timer_d    = '0;
                state_d    = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: if (locked_sync_q) begin
                status_d = 2'd0;
                state_d  = S_FIN;
            end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                status_d = 2'd3;
                state_d  = S_FIN;
            end else begin
                timer_d = timer_q + TW'(1);
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (acc_to) begin
            status_d   = 2'd3;
            mmcm_rst_d = 1'b0;
            state_d    = S_FIN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            timer_q       <= '0;
            pending_q     <= 1'b0;
            done_q        <= 1'b0;
            status_q      <= 2'd0;
            mmcm_rst_q    <= 1'b0;
            drp_daddr_q   <= '0;
            drp_di_q      <= '0;
            drp_den_q     <= 1'b0;
            drp_dwe_q     <= 1'b0;
            locked_meta_q <= 1'b0;
            locked_sync_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            timer_q       <= timer_d;
            pending_q     <= pending_d;
            done_q        <= done_d;
            status_q      <= status_d;
            mmcm_rst_q    <= mmcm_rst_d;
            drp_daddr_q   <= drp_daddr_d;
            drp_di_q      <= drp_di_d;
            drp_den_q     <= drp_den_d;
            drp_dwe_q     <= drp_dwe_d;
            locked_meta_q <= locked_meta_d;
            locked_sync_q <= locked_sync_d;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign status    = status_q;
    assign mmcm_rst  = mmcm_rst_q;
    assign drp_daddr = drp_daddr_q;
    assign drp_di    = drp_di_q;
    assign drp_den   = drp_den_q;
    assign drp_dwe   = drp_dwe_q;
endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// tb/tb_mmcm_drp_sequencer.sv - scoreboard bench for mmcm_drp_sequencer with DRP and MMCM lock models
module tb_mmcm_drp_sequencer;
    localparam int LOCK_TO = 150;
    localparam int DRP_TO  = 20;
`ifdef MMCM_DRP_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_div = 8'd0;
    logic        cfg_ready, busy, done, mmcm_rst;
    logic [1:0]  status;
    logic        mmcm_locked = 1'b0;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'd0;
    logic        drp_den, drp_dwe;
    logic        drp_drdy = 1'b0;

    mmcm_drp_sequencer #(.LOCK_TIMEOUT(LOCK_TO), .DRP_TIMEOUT(DRP_TO)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .busy(busy), .done(done), .status(status),
        .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
        .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_drdy(drp_drdy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] st; bit touch; bit lock_to; int lock_dly; } exp_t;
    typedef struct { logic [6:0] addr; logic [15:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rst_fall_cyc = 0;
    bit prev_rst = 1'b0;
    bit saw_den = 1'b0, saw_rst = 1'b0;
    logic [15:0] mem [128];

    bit outstanding = 1'b0, orphan = 1'b0, cur_we = 1'b0;
    bit drdy_hold = 1'b0, stall_wr = 1'b0, corrupt = 1'b0;
    logic [6:0]  cur_addr = 7'd0;
    logic [15:0] cur_di = 16'd0;
    int cd = 0;
    int lock_delay = -1;
    int lock_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic fail(input string name, input int act, input int req);
        total++;
        bad++;
        $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    // Reference encoding straight from the divide rules: halves, remainder, modulo-64 fields.
    function automatic logic [15:0] ref_reg1(input logic [15:0] rd, input int d);
        int hi, lo;
        hi = d / 2;
        lo = d - hi;
        return (rd & 16'hF000) | 16'(((hi % 64) * 64) + (lo % 64));
    endfunction

    function automatic logic [15:0] ref_reg2(input logic [15:0] rd, input int d);
        return (rd & 16'hFF3F) | 16'(((d % 2) * 128) + ((d == 1) ? 64 : 0));
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mmcm_rst) begin
            lock_cnt    = 0;
            mmcm_locked = 1'b0;
        end else begin
            if (lock_cnt < 100000) lock_cnt++;
            mmcm_locked = (lock_delay >= 0) && (lock_cnt >= lock_delay);
        end
    end

    always @(negedge clk) begin : drp_model
        wr_t w;
        drp_drdy = 1'b0;
        if (drp_dwe) chk("dwe_only_with_den", drp_den, 1'b1);
        if (drp_den) begin
            chk("den_no_overlap", outstanding, 1'b0);
            chk("rst_high_during_drp", mmcm_rst, 1'b1);
            outstanding = 1'b1;
            orphan      = 1'b0;
            cur_addr    = drp_daddr;
            cur_we      = drp_dwe;
            cur_di      = drp_di;
            cd          = $urandom_range(1, 3);
            if (drp_dwe) begin
                if (wr_q.size() == 0) begin
                    fail("unexpected_write", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_addr", drp_daddr, w.addr);
                    chk("write_data", drp_di, w.data);
                end
            end
        end else if (outstanding) begin
            if (!orphan) begin
                chk("daddr_stable", drp_daddr, cur_addr);
                chk("di_stable", drp_di, cur_di);
            end
            if (!(drdy_hold || (stall_wr && cur_we))) begin
                cd--;
                if (cd <= 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = mem[cur_addr] ^ ((corrupt && cur_addr == 7'h0A) ? 16'h0008 : 16'h0000);
                    if (cur_we) mem[cur_addr] = cur_di;
                    outstanding = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (mmcm_rst) saw_rst = 1'b1;
            if (drp_den) saw_den = 1'b1;
            if (prev_rst && !mmcm_rst) rst_fall_cyc = cyc;
            if (done) begin
                if (exp_q.size() == 0) begin
                    fail("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("status", status, e.st);
                    chk("drp_touched", saw_den, e.touch);
                    chk("rst_touched", saw_rst, e.touch);
                    chk("rst_low_at_done", mmcm_rst, 1'b0);
                    chk("ready_with_done", cfg_ready, 1'b1);
                    if (e.lock_to)
                        chk_range("lock_timeout_latency", cyc - rst_fall_cyc, LOCK_TO, LOCK_TO + 2);
                    else if (e.st == 2'd0)
                        chk_range("lock_latency", cyc - rst_fall_cyc, e.lock_dly + 2, e.lock_dly + 4);
                end
            end
        end
        prev_rst = mmcm_rst;
    end

    task automatic issue(input logic [7:0] d, input bit is_bad);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 1000) begin @(negedge clk); n++; end
        chk("ready_before_issue", cfg_ready, 1'b1);
        cfg_div   = d;
        cfg_valid = 1'b1;
        saw_den   = 1'b0;
        saw_rst   = 1'b0;
        @(posedge clk);
        #1 cfg_div = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk("rst_low_1_after_accept", mmcm_rst, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        chk("rst_2_after_accept", mmcm_rst, !is_bad);
        #1;
        if (is_bad) chk("bad_div_done_latency", exp_q.size(), 0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); #1; n++; end
        if (exp_q.size() != 0) begin
            fail(name, exp_q.size(), 0);
            exp_q.delete();
            wr_q.delete();
        end
    endtask

    task automatic do_req(input int d, input int ld, input bit corr, input bit hold);
        exp_t e;
        wr_t w;
        bit is_bad;
        is_bad     = (d == 0) || (d > 128);
        lock_delay = ld;
        corrupt    = corr;
        drdy_hold  = hold;
        e.touch    = !is_bad;
        e.lock_to  = 1'b0;
        e.lock_dly = ld;
        if (is_bad) e.st = 2'd1;
        else if (hold) e.st = 2'd3;
        else if (corr && VERIFY) e.st = 2'd2;
        else if (ld < 0) begin e.st = 2'd3; e.lock_to = 1'b1; end
        else e.st = 2'd0;
        if (!is_bad && !hold) begin
            w.addr = 7'h0A; w.data = ref_reg1(mem[7'h0A] ^ (corr ? 16'h0008 : 16'h0000), d);
            wr_q.push_back(w);
            w.addr = 7'h0B; w.data = ref_reg2(mem[7'h0B], d);
            wr_q.push_back(w);
        end
        exp_q.push_back(e);
        issue(d[7:0], is_bad);
        wait_done("request_timeout");
        chk("writes_all_seen", wr_q.size(), 0);
        if (hold) begin
            orphan    = 1'b1;
            drdy_hold = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int tab[11];
        int n;
        int d;
        wr_t w;
        tab = '{0, 1, 2, 3, 63, 64, 65, 127, 128, 129, 255};
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_cfg_ready", cfg_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_status", status, 2'd0);
        chk("reset_mmcm_rst", mmcm_rst, 1'b0);
        chk("reset_den", drp_den, 1'b0);
        chk("reset_dwe", drp_dwe, 1'b0);
        chk("reset_daddr", drp_daddr, 7'd0);
        chk("reset_di", drp_di, 16'd0);
        reset = 1'b0;

        mem[7'h0A] = 16'hA0A0; mem[7'h0B] = 16'hFFFF;
        do_req(10, 100, 1'b0, 1'b0);
        chk("div10_reg1", mem[7'h0A], 16'hA145);
        chk("div10_reg2", mem[7'h0B], 16'hFF3F);

        do_req(0, 20, 1'b0, 1'b0);
        do_req(200, 20, 1'b0, 1'b0);

        mem[7'h0A] = 16'h5FFF; mem[7'h0B] = 16'h0000;
        do_req(1, 15, 1'b0, 1'b0);
        chk("div1_reg1_fields", mem[7'h0A], 16'h5001);
        chk("div1_reg2_fields", mem[7'h0B], 16'h00C0);

        mem[7'h0A] = 16'h3FFF; mem[7'h0B] = 16'hFFFF;
        do_req(128, 30, 1'b0, 1'b0);
        chk("div128_reg1", mem[7'h0A], 16'h3000);
        chk("div128_reg2", mem[7'h0B], 16'hFF3F);

        do_req(20, -1, 1'b0, 1'b0);
        do_req(37, 10, 1'b0, 1'b1);

        mem[7'h0A] = 16'h1234; mem[7'h0B] = 16'h5678;
        lock_delay = 10; corrupt = 1'b0; stall_wr = 1'b1;
        w.addr = 7'h0A; w.data = ref_reg1(16'h1234, 33);
        wr_q.push_back(w);
        issue(8'd33, 1'b0);
        n = 0;
        while (!(outstanding && cur_we) && n < 500) begin @(negedge clk); #1; n++; end
        chk("wr1_reached", outstanding && cur_we, 1'b1);
        @(negedge clk);
        orphan = 1'b1;
        reset  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_ready", cfg_ready, 1'b1);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_mmcm_rst", mmcm_rst, 1'b0);
        chk("midreset_done", done, 1'b0);
        reset = 1'b0;
        wr_q.delete();
        stall_wr = 1'b0;
        repeat (8) @(negedge clk);
        chk("late_drdy_busy", busy, 1'b0);
        chk("late_drdy_rst", mmcm_rst, 1'b0);
        do_req(33, 12, 1'b0, 1'b0);

        mem[7'h0A] = 16'hBEEF; mem[7'h0B] = 16'hCAFE;
        do_req(7, 25, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: d = tab[$urandom_range(0, 10)];
                3: d = $urandom_range(0, 255);
                default: d = $urandom_range(1, 128);
            endcase
            mem[7'h0A] = 16'($urandom);
            mem[7'h0B] = 16'($urandom);
            do_req(d, $urandom_range(1, 100), 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
